universal_register: RTL and testbench
=====================================

UNIVERSAL_REGISTER -- requirements
Module: universal_register

Interface
REQ-001 Parameter: WIDTH, 8, register width in bits; legal range 2..32.
REQ-002 Parameter: RESET_VAL, 0, value loaded into Q on reset; truncated to WIDTH bits.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: en  input  1  operation enable; 0 = hold.
REQ-006 Port: mode  input  3  operation select (REQ-012).
REQ-007 Port: D  input  WIDTH  parallel load data.
REQ-008 Port: sin  input  1  serial input bit for shift modes.
REQ-009 Port: Q  output  WIDTH  registered contents.
REQ-010 Port: Qbar  output  WIDTH  bitwise complement of Q, always ~Q, never independently stored.
REQ-011 Port: sout  output  1  registered bit shifted or rotated out. tc  output  1  registered wrap pulse.

Function
REQ-012 Mode encoding: 000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 INC, 111 DEC.
REQ-013 All operations: single-cycle latency; result visible on Q on the edge after en=1 is sampled.
REQ-014 en=0: Q and sout hold; tc goes 0.
REQ-015 HOLD (en=1): Q and sout unchanged; tc goes 0.
REQ-016 LOAD: Q <= D; sout unchanged.
REQ-017 SHL: Q <= {Q[WIDTH-2:0], sin}; sout <= old Q[WIDTH-1].
REQ-018 SHR: Q <= {sin, Q[WIDTH-1:1]}; sout <= old Q[0].
REQ-019 ROL: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}; sout <= old Q[WIDTH-1]; sin ignored.
REQ-020 ROR: Q <= {Q[0], Q[WIDTH-1:1]}; sout <= old Q[0]; sin ignored.
REQ-021 INC: Q <= (Q+1) mod 2^WIDTH; sout unchanged.
REQ-022 DEC: Q <= (Q-1) mod 2^WIDTH; sout unchanged.
REQ-023 tc: 1 for exactly one cycle after INC from all-ones (to 0) or DEC from 0 (to all-ones); 0 after every other edge, including consecutive non-wrapping INC/DEC.
REQ-024 Back-to-back wraps, e.g. repeated INC with WIDTH=2 from 3: tc pulses on every wrapping edge and stays 0 in between.
REQ-025 Mode changes take effect on the next edge, with no dead cycle; mode is a don't-care while en=0.
REQ-026 No combinational path from any input to Q, sout, or tc; Qbar depends only on Q.

Reset
REQ-027 rst=1 at an edge: Q <= RESET_VAL, sout <= 0, tc <= 0, regardless of en, mode, or D.
REQ-028 rst has priority over all operations; asserting rst mid-sequence (e.g. during INC run) discards the operation on that edge.
REQ-029 Outputs are undefined before the first reset edge; the bench does not check them.
REQ-030 After rst deasserts, the first operation executes on the first edge with rst=0 and en=1.

Structure
REQ-031 Shared package universal_register_pkg holds the mode localparams (MODE_HOLD..MODE_DEC) and the mode width constant 3.
REQ-032 One sub-module, ureg_bit: a 1-bit flip-flop with synchronous reset value, enable, and 8:1 next-state mux; instantiated WIDTH times via generate.
REQ-033 INC/DEC carry/borrow chain and tc/sout logic live in the top level, not in ureg_bit.

Verification (WIDTH=8, RESET_VAL=0 unless stated)
REQ-034 Reset, then LOAD D=8'hA5 -> Q=A5, Qbar=5A, tc=0, sout=0.
REQ-035 Q=A5, SHL with sin=1 for 2 cycles -> Q=4B then 97; sout=1 then 0.
REQ-036 Q=81, ROR once, then ROL once -> Q=C0 with sout=1, then Q=81 with sout=1.
REQ-037 LOAD FE, then INC x3 -> Q=FF, 00, 01; tc=0, 1, 0.
REQ-038 Q=00, DEC with en toggling 1,0,1 -> Q=FF (tc=1), FF (tc=0), FE (tc=0).
REQ-039 RESET_VAL=8'h3C, INC run, rst=1 with en=1 mode=LOAD D=77 -> Q=3C, sout=0, tc=0.

Source files
------------

// File: rtl/universal_register_pkg.sv
// Shared definitions for the universal register: operation codes and
// small decode helpers used by the top level and by the bench.
package universal_register_pkg;

    localparam int MODE_W    = 3;
    localparam int NUM_MODES = 1 << MODE_W;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;
    localparam logic [MODE_W-1:0] MODE_INC  = 3'b110;
    localparam logic [MODE_W-1:0] MODE_DEC  = 3'b111;

    // True for the operations that push the MSB out through sout.
    function automatic logic mode_exits_msb(input logic [MODE_W-1:0] mode);
        return (mode == MODE_SHL) || (mode == MODE_ROL);
    endfunction

    // True for the operations that push the LSB out through sout.
    function automatic logic mode_exits_lsb(input logic [MODE_W-1:0] mode);
        return (mode == MODE_SHR) || (mode == MODE_ROR);
    endfunction

endpackage

// File: rtl/ureg_bit.sv
// One bit of the universal register: a flip-flop with a synchronous reset
// value, an enable, and an 8:1 next-state mux indexed by the mode code.
// The caller supplies one candidate next value per mode.
module ureg_bit
    import universal_register_pkg::*;
#(
    parameter logic RST_BIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [MODE_W-1:0]    sel,
    input  logic [NUM_MODES-1:0] cand,
    output logic                 q
);

    // Reset wins, otherwise an enabled edge takes the candidate chosen by sel.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_BIT;
        end else if (en) begin
            q <= cand[sel];
        end
    end

endmodule

// File: rtl/universal_register.sv
// Universal register: hold, parallel load, shift and rotate in both
// directions, and increment/decrement with a registered wrap pulse (tc).
// Per-bit storage lives in ureg_bit; the arithmetic chain and the sout/tc
// flops are kept here so each bit cell stays a plain mux + flop.
module universal_register
    import universal_register_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] RESET_VAL = 32'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  D,
    input  logic              sin,
    output logic [WIDTH-1:0]  Q,
    output logic [WIDTH-1:0]  Qbar,
    output logic              sout,
    output logic              tc
);

    localparam logic [WIDTH-1:0] RST_Q = RESET_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] shl_val;
    logic [WIDTH-1:0] shr_val;
    logic [WIDTH-1:0] rol_val;
    logic [WIDTH-1:0] ror_val;
    logic [WIDTH-1:0] inc_val;
    logic [WIDTH-1:0] dec_val;
    logic             carry;
    logic             borrow;
    logic             wrap_next;

    // Shift and rotate results are pure rewiring of the current contents.
    assign shl_val = {Q[WIDTH-2:0], sin};
    assign shr_val = {sin, Q[WIDTH-1:1]};
    assign rol_val = {Q[WIDTH-2:0], Q[WIDTH-1]};
    assign ror_val = {Q[0], Q[WIDTH-1:1]};

    // Ripple carry/borrow chain; the carry or borrow falling off the top
    // marks the all-ones or all-zeros wrap that drives tc.
    always_comb begin
        inc_val = '0;
        dec_val = '0;
        carry   = 1'b1;
        borrow  = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            inc_val[i] = Q[i] ^ carry;
            dec_val[i] = Q[i] ^ borrow;
            carry      = carry & Q[i];
            borrow     = borrow & ~Q[i];
        end
    end

    // A wrap pulse is produced only by an enabled INC/DEC that overflows.
    always_comb begin
        wrap_next = 1'b0;
        if (en) begin
            if (mode == MODE_INC) begin
                wrap_next = carry;
            end else if (mode == MODE_DEC) begin
                wrap_next = borrow;
            end
        end
    end

    // One bit cell per register bit, each fed its eight candidate values
    // ordered by mode code.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [NUM_MODES-1:0] cand;

        assign cand[MODE_HOLD] = Q[i];
        assign cand[MODE_LOAD] = D[i];
        assign cand[MODE_SHL]  = shl_val[i];
        assign cand[MODE_SHR]  = shr_val[i];
        assign cand[MODE_ROL]  = rol_val[i];
        assign cand[MODE_ROR]  = ror_val[i];
        assign cand[MODE_INC]  = inc_val[i];
        assign cand[MODE_DEC]  = dec_val[i];

        ureg_bit #(
            .RST_BIT (RST_Q[i])
        ) u_bit (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .sel  (mode),
            .cand (cand),
            .q    (Q[i])
        );
    end

    // sout captures the bit leaving the register on shifts/rotates and
    // otherwise holds; tc is a one-edge pulse that any other edge clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            sout <= 1'b0;
            tc   <= 1'b0;
        end else begin
            tc <= wrap_next;
            if (en && mode_exits_msb(mode)) begin
                sout <= Q[WIDTH-1];
            end else if (en && mode_exits_lsb(mode)) begin
                sout <= Q[0];
            end
        end
    end

    assign Qbar = ~Q;

endmodule

// File: tb/tb_universal_register.sv
// Bench for universal_register: three instances (8-bit reset 00, 8-bit
// reset 3C, 2-bit reset 0) driven by directed steps followed by a random
// run against a behavioural model on the first instance. Expected values
// go into a scoreboard queue at drive time and are popped after the edge.
module tb_universal_register;
    import universal_register_pkg::*;

    typedef struct {
        int          dut;
        string       tag;
        logic [7:0]  q;
        logic        sout;
        logic        tc;
    } exp_t;

    logic       clk;
    logic       rst_s  [3];
    logic       en_s   [3];
    logic [2:0] mode_s [3];
    logic [7:0] d_s    [3];
    logic       sin_s  [3];

    logic [7:0] q0, qb0, q1, qb1;
    logic [1:0] q2, qb2;
    logic       so0, so1, so2, tc0, tc1, tc2;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Behavioural model state for the random run on instance 0
    logic [7:0] mq;
    logic       msout;
    logic       mtc;

    universal_register #(.WIDTH(8), .RESET_VAL(32'h00)) u_dut0 (
        .clk(clk), .rst(rst_s[0]), .en(en_s[0]), .mode(mode_s[0]),
        .D(d_s[0]), .sin(sin_s[0]), .Q(q0), .Qbar(qb0), .sout(so0), .tc(tc0));

    universal_register #(.WIDTH(8), .RESET_VAL(32'h3C)) u_dut1 (
        .clk(clk), .rst(rst_s[1]), .en(en_s[1]), .mode(mode_s[1]),
        .D(d_s[1]), .sin(sin_s[1]), .Q(q1), .Qbar(qb1), .sout(so1), .tc(tc1));

    universal_register #(.WIDTH(2), .RESET_VAL(32'h0)) u_dut2 (
        .clk(clk), .rst(rst_s[2]), .en(en_s[2]), .mode(mode_s[2]),
        .D(d_s[2][1:0]), .sin(sin_s[2]), .Q(q2), .Qbar(qb2), .sout(so2), .tc(tc2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pop the oldest expectation and compare it with the addressed instance.
    task automatic checkOutput();
        exp_t       e;
        logic [7:0] oq, oqb, eqb;
        logic       os, ot;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard_empty");
            return;
        end
        e = sb.pop_front();
        case (e.dut)
            0:       begin oq = q0; oqb = qb0; os = so0; ot = tc0; eqb = ~e.q; end
            1:       begin oq = q1; oqb = qb1; os = so1; ot = tc1; eqb = ~e.q; end
            default: begin
                oq = {6'b0, q2}; oqb = {6'b0, qb2}; os = so2; ot = tc2;
                eqb = {6'b0, ~e.q[1:0]};
            end
        endcase
        checks++;
        assert (oq === e.q) else begin
            errors++;
            $error("[TB] FAIL %s.Q dut%0d got=%h exp=%h", e.tag, e.dut, oq, e.q);
        end
        checks++;
        assert (oqb === eqb) else begin
            errors++;
            $error("[TB] FAIL %s.Qbar dut%0d got=%h exp=%h", e.tag, e.dut, oqb, eqb);
        end
        checks++;
        assert (os === e.sout) else begin
            errors++;
            $error("[TB] FAIL %s.sout dut%0d got=%b exp=%b", e.tag, e.dut, os, e.sout);
        end
        checks++;
        assert (ot === e.tc) else begin
            errors++;
            $error("[TB] FAIL %s.tc dut%0d got=%b exp=%b", e.tag, e.dut, ot, e.tc);
        end
    endtask

    // Drive one edge's worth of inputs into one instance (others held),
    // record the expected result, then check it just after the edge.
    task automatic applyStimulus(input int dut, input logic r, input logic e,
                                 input logic [2:0] m, input logic [7:0] d,
                                 input logic s, input logic [7:0] eq,
                                 input logic es, input logic et, input string tag);
        exp_t x;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            rst_s[k] = 1'b0;
            en_s[k]  = 1'b0;
        end
        rst_s[dut]  = r;
        en_s[dut]   = e;
        mode_s[dut] = m;
        d_s[dut]    = d;
        sin_s[dut]  = s;
        x.dut = dut; x.tag = tag; x.q = eq; x.sout = es; x.tc = et;
        sb.push_back(x);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_s[k] = 1'b0; en_s[k] = 1'b0; mode_s[k] = MODE_HOLD;
            d_s[k] = 8'h00; sin_s[k] = 1'b0;
        end

        // Instance 0: WIDTH=8, RESET_VAL=00
        applyStimulus(0, 1, 0, MODE_HOLD, 8'h00, 0, 8'h00, 0, 0, "reset0");
        applyStimulus(0, 0, 1, MODE_LOAD, 8'hA5, 0, 8'hA5, 0, 0, "loadA5");
        applyStimulus(0, 0, 1, MODE_SHL,  8'h00, 1, 8'h4B, 1, 0, "shl1");
        applyStimulus(0, 0, 1, MODE_SHL,  8'h00, 1, 8'h97, 0, 0, "shl2");
        applyStimulus(0, 0, 1, MODE_LOAD, 8'h81, 0, 8'h81, 0, 0, "load81");
        applyStimulus(0, 0, 1, MODE_ROR,  8'h00, 0, 8'hC0, 1, 0, "ror");
        applyStimulus(0, 0, 1, MODE_ROL,  8'h00, 0, 8'h81, 1, 0, "rol");
        applyStimulus(0, 0, 1, MODE_LOAD, 8'hFE, 0, 8'hFE, 1, 0, "loadFE");
        applyStimulus(0, 0, 1, MODE_INC,  8'h00, 0, 8'hFF, 1, 0, "inc1");
        applyStimulus(0, 0, 1, MODE_INC,  8'h00, 0, 8'h00, 1, 1, "inc2wrap");
        applyStimulus(0, 0, 1, MODE_INC,  8'h00, 0, 8'h01, 1, 0, "inc3");
        applyStimulus(0, 0, 1, MODE_LOAD, 8'h00, 0, 8'h00, 1, 0, "load00");
        applyStimulus(0, 0, 1, MODE_DEC,  8'h00, 0, 8'hFF, 1, 1, "dec1wrap");
        applyStimulus(0, 0, 0, MODE_DEC,  8'h00, 0, 8'hFF, 1, 0, "decEnOff");
        applyStimulus(0, 0, 1, MODE_DEC,  8'h00, 0, 8'hFE, 1, 0, "dec2");
        applyStimulus(0, 0, 1, MODE_SHR,  8'h00, 0, 8'h7F, 0, 0, "shr");
        applyStimulus(0, 0, 1, MODE_SHR,  8'h00, 1, 8'hBF, 1, 0, "shrSin");
        applyStimulus(0, 0, 1, MODE_HOLD, 8'h12, 1, 8'hBF, 1, 0, "hold");
        applyStimulus(0, 1, 1, MODE_INC,  8'h00, 0, 8'h00, 0, 0, "rstOverInc");
        applyStimulus(0, 0, 0, MODE_LOAD, 8'h55, 0, 8'h00, 0, 0, "enOffLoad");

        // Instance 1: RESET_VAL=3C, reset lands in the middle of an INC run
        applyStimulus(1, 1, 0, MODE_HOLD, 8'h00, 0, 8'h3C, 0, 0, "reset3C");
        applyStimulus(1, 0, 1, MODE_INC,  8'h00, 0, 8'h3D, 0, 0, "inc3D");
        applyStimulus(1, 0, 1, MODE_ROR,  8'h00, 0, 8'h9E, 1, 0, "ror9E");
        applyStimulus(1, 0, 1, MODE_INC,  8'h00, 0, 8'h9F, 1, 0, "inc9F");
        applyStimulus(1, 1, 1, MODE_LOAD, 8'h77, 0, 8'h3C, 0, 0, "rstOverLoad");
        applyStimulus(1, 0, 1, MODE_LOAD, 8'h77, 0, 8'h77, 0, 0, "firstOp");

        // Instance 2: WIDTH=2, wraps on consecutive edges
        applyStimulus(2, 1, 0, MODE_HOLD, 8'h00, 0, 8'h00, 0, 0, "reset2b");
        applyStimulus(2, 0, 1, MODE_LOAD, 8'h03, 0, 8'h03, 0, 0, "load3");
        applyStimulus(2, 0, 1, MODE_INC,  8'h00, 0, 8'h00, 0, 1, "incWrapA");
        applyStimulus(2, 0, 1, MODE_DEC,  8'h00, 0, 8'h03, 0, 1, "decWrap");
        applyStimulus(2, 0, 1, MODE_INC,  8'h00, 0, 8'h00, 0, 1, "incWrapB");
        applyStimulus(2, 0, 1, MODE_INC,  8'h00, 0, 8'h01, 0, 0, "inc1");
        applyStimulus(2, 0, 1, MODE_INC,  8'h00, 0, 8'h02, 0, 0, "inc2");
        applyStimulus(2, 0, 1, MODE_INC,  8'h00, 0, 8'h03, 0, 0, "inc3");
        applyStimulus(2, 0, 1, MODE_INC,  8'h00, 0, 8'h00, 0, 1, "incWrapC");
        applyStimulus(2, 0, 1, MODE_SHL,  8'h00, 1, 8'h01, 0, 0, "shl2b");
        applyStimulus(2, 0, 1, MODE_ROL,  8'h00, 0, 8'h02, 0, 0, "rol2b");
        applyStimulus(2, 0, 1, MODE_ROL,  8'h00, 0, 8'h01, 1, 0, "rol2bOut");

        // Random run on instance 0 against a behavioural model (starts at 00)
        mq    = 8'h00;
        msout = 1'b0;
        for (int n = 0; n < 60; n++) begin
            logic [2:0] m;
            logic [7:0] d;
            logic       s;
            logic       e;
            m = 3'($urandom_range(0, 7));
            d = 8'($urandom);
            s = 1'($urandom_range(0, 1));
            e = ($urandom_range(0, 3) != 0);
            mtc = 1'b0;
            if (e) begin
                case (m)
                    MODE_LOAD: mq = d;
                    MODE_SHL:  begin msout = mq[7]; mq = {mq[6:0], s};     end
                    MODE_SHR:  begin msout = mq[0]; mq = {s, mq[7:1]};     end
                    MODE_ROL:  begin msout = mq[7]; mq = {mq[6:0], mq[7]}; end
                    MODE_ROR:  begin msout = mq[0]; mq = {mq[0], mq[7:1]}; end
                    MODE_INC:  begin mtc = (mq == 8'hFF); mq = mq + 8'd1;  end
                    MODE_DEC:  begin mtc = (mq == 8'h00); mq = mq - 8'd1;  end
                    default:   ;
                endcase
            end
            applyStimulus(0, 0, e, m, d, s, mq, msout, mtc, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
